// File: rtl/serial_word_feeder_if.sv
// -----------------------------------------------------------------------------
// serial_word_feeder_if
// Handshake and serial-stream bundle between a word producer, the
// serial_word_feeder and the downstream two's complement converter.
//
//   load        producer -> feeder   request to accept din (honoured when ready)
//   din         producer -> feeder   parallel word, WIDTH bits
//   ready       feeder -> producer   idle and able to accept a word
//   out         feeder -> converter  serial data bit, LSB first
//   bit_valid   feeder -> consumer   out carries a word bit this cycle
//   conv_reset  feeder -> converter  one-cycle frame-clear pulse
//   done        feeder -> producer   one-cycle pulse after the last bit
//
// master: the word producer side; slave: the feeder itself.
// -----------------------------------------------------------------------------
interface serial_word_feeder_if #(
    parameter int WIDTH = 8
);
    logic             load;
    logic [WIDTH-1:0] din;
    logic             ready;
    logic             out;
    logic             bit_valid;
    logic             conv_reset;
    logic             done;

    modport master (
        output load,
        output din,
        input  ready,
        input  out,
        input  bit_valid,
        input  conv_reset,
        input  done
    );

    modport slave (
        input  load,
        input  din,
        output ready,
        output out,
        output bit_valid,
        output conv_reset,
        output done
    );
endinterface

// File: rtl/serial_word_feeder.sv
// -----------------------------------------------------------------------------
// serial_word_feeder
// Upstream stage of the serial two's complement converter. Accepts a parallel
// WIDTH-bit word through a ready/load handshake, issues a one-cycle
// frame-clear (conv_reset) to the converter, shifts the word out LSB-first one
// bit per clock, then pulses done. One word every WIDTH+3 cycles.
//
// Ports:
//   clk    system clock, all state changes on the rising edge
//   reset  synchronous, active-high; abandons any word in flight
//   bus    serial_word_feeder_if.slave (load, din in; ready, out, bit_valid,
//          conv_reset, done out). All outputs are registered.
//
// Parameter:
//   WIDTH  bits per word, legal range 2..32
// -----------------------------------------------------------------------------
module serial_word_feeder #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_word_feeder_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_r;
    logic [WIDTH-1:0] shift_r;
    logic [CW-1:0]    cnt_r;
    logic             ready_r;
    logic             out_r;
    logic             bit_valid_r;
    logic             conv_reset_r;
    logic             done_r;

    logic [1:0]       state_nx_s;
    logic [WIDTH-1:0] shift_nx_s;
    logic [CW-1:0]    cnt_nx_s;
    logic             ready_nx_s;
    logic             out_nx_s;
    logic             bit_valid_nx_s;
    logic             conv_reset_nx_s;
    logic             done_nx_s;

    // Next-state and next-output decode. Outputs are computed for the state
    // being entered so that, once registered, they line up with that state.
    always_comb begin
        state_nx_s      = state_r;
        shift_nx_s      = shift_r;
        cnt_nx_s        = cnt_r;
        ready_nx_s      = 1'b0;
        out_nx_s        = 1'b0;
        bit_valid_nx_s  = 1'b0;
        conv_reset_nx_s = 1'b0;
        done_nx_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.load) begin
                    state_nx_s      = ST_CLEAR;
                    shift_nx_s      = bus.din;
                    cnt_nx_s        = CNT_ZERO;
                    conv_reset_nx_s = 1'b1;
                end else begin
                    ready_nx_s = 1'b1;
                end
            end
            ST_CLEAR: begin
                // Present bit 0 in the first SHIFT cycle.
                state_nx_s     = ST_SHIFT;
                out_nx_s       = shift_r[0];
                shift_nx_s     = {1'b0, shift_r[WIDTH-1:1]};
                bit_valid_nx_s = 1'b1;
            end
            ST_SHIFT: begin
                // cnt_r is the index of the bit currently on out.
                if (cnt_r == CNT_LAST) begin
                    state_nx_s = ST_DONE;
                    done_nx_s  = 1'b1;
                end else begin
                    cnt_nx_s       = cnt_r + CNT_ONE;
                    out_nx_s       = shift_r[0];
                    shift_nx_s     = {1'b0, shift_r[WIDTH-1:1]};
                    bit_valid_nx_s = 1'b1;
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
                ready_nx_s = 1'b1;
            end
            default: begin
                state_nx_s = ST_IDLE;
                shift_nx_s = {WIDTH{1'b0}};
                cnt_nx_s   = CNT_ZERO;
                ready_nx_s = 1'b1;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            shift_r      <= {WIDTH{1'b0}};
            cnt_r        <= CNT_ZERO;
            ready_r      <= 1'b1;
            out_r        <= 1'b0;
            bit_valid_r  <= 1'b0;
            conv_reset_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            shift_r      <= shift_nx_s;
            cnt_r        <= cnt_nx_s;
            ready_r      <= ready_nx_s;
            out_r        <= out_nx_s;
            bit_valid_r  <= bit_valid_nx_s;
            conv_reset_r <= conv_reset_nx_s;
            done_r       <= done_nx_s;
        end
    end

    assign bus.ready      = ready_r;
    assign bus.out        = out_r;
    assign bus.bit_valid  = bit_valid_r;
    assign bus.conv_reset = conv_reset_r;
    assign bus.done       = done_r;
endmodule

// File: tb/tb_serial_word_feeder.sv
// -----------------------------------------------------------------------------
// tb_serial_word_feeder
// Self-checking bench. A timeline model predicts every output from the number
// of cycles elapsed since a word was accepted; a serial two's complement
// converter model checks the integration behaviour.
// -----------------------------------------------------------------------------
module tb_serial_word_feeder;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;

    serial_word_feeder_if #(.WIDTH(W)) bus ();

    serial_word_feeder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks  = 0;
    int errors  = 0;
    int tick_no = 0;

    // Timeline model: phase = cycles since the accepting edge.
    // phase 1 frame-clear, 2..W+1 bits, W+2 done, then idle again.
    bit         m_active = 1'b0;
    int         m_phase  = 0;
    logic [W-1:0] m_word = '0;
    logic [4:0] exp_v;
    logic [4:0] got_v;

    // {ready, out, bit_valid, conv_reset, done}
    assign got_v = {bus.ready, bus.out, bus.bit_valid, bus.conv_reset, bus.done};

    task automatic tick();
        bit ready_pre;
        @(posedge clk);
        ready_pre = !m_active;
        if (reset) begin
            m_active = 1'b0;
        end else if (ready_pre && bus.load) begin
            m_active = 1'b1;
            m_phase  = 1;
            m_word   = bus.din;
        end else if (m_active) begin
            m_phase++;
            if (m_phase == W + 3) m_active = 1'b0;
        end
        if (!m_active) begin
            exp_v = 5'b10000;
        end else begin
            exp_v    = 5'b00000;
            exp_v[1] = (m_phase == 1);
            if (m_phase >= 2 && m_phase <= W + 1) begin
                exp_v[2] = 1'b1;
                exp_v[3] = m_word[m_phase-2];
            end
            exp_v[0] = (m_phase == W + 2);
        end
        #1;
        tick_no++;
    endtask

    task automatic test_reset();
        bus.load = 1'b0;
        bus.din  = '0;
        reset    = 1'b1;
        tick();
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL reset_state tick %0d got %b exp %b", tick_no, got_v, exp_v);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (got_v !== 5'b10000 || got_v !== exp_v) begin
                errors++;
                $display("FAIL reset_idle tick %0d got %b exp %b", tick_no, got_v, exp_v);
            end
        end
    endtask

    task automatic test_single_word(input logic [W-1:0] w, input logic [W-1:0] conv_exp,
                                    input string name);
        logic [W-1:0] stream = '0;
        logic [W-1:0] conv   = '0;
        bit seen = 1'b0;
        int nbits = 0, ndone = 0, nclr = 0;
        for (int i = 0; i < W + 4; i++) begin
            bus.load = (i == 0);
            bus.din  = (i == 0) ? w : W'($urandom);
            tick();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL %s_cycle tick %0d got %b exp %b", name, tick_no, got_v, exp_v);
            end
            if (bus.conv_reset) begin
                seen = 1'b0;
                nclr++;
            end
            if (bus.bit_valid) begin
                stream = {bus.out, stream[W-1:1]};
                conv   = {bus.out ^ seen, conv[W-1:1]};
                seen   = seen | bus.out;
                nbits++;
            end
            if (bus.done) ndone++;
        end
        bus.load = 1'b0;
        checks++;
        if (stream !== w || nbits != W) begin
            errors++;
            $display("FAIL %s_stream got %h (%0d bits) exp %h (%0d bits)", name, stream, nbits, w, W);
        end
        checks++;
        if (conv !== conv_exp) begin
            errors++;
            $display("FAIL %s_converter got %h exp %h", name, conv, conv_exp);
        end
        checks++;
        if (ndone != 1 || nclr != 1) begin
            errors++;
            $display("FAIL %s_pulses got done=%0d clr=%0d exp done=1 clr=1", name, ndone, nclr);
        end
    endtask

    task automatic test_load_while_busy();
        logic [W-1:0] stream = '0;
        int nbits = 0, ndone = 0;
        for (int i = 0; i < 20; i++) begin
            bus.load = (i == 0) || (i == 4);
            bus.din  = (i == 0) ? 8'hE8 : 8'h55;
            tick();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL busy_cycle tick %0d got %b exp %b", tick_no, got_v, exp_v);
            end
            if (bus.bit_valid) begin
                if (nbits < W) stream = {bus.out, stream[W-1:1]};
                nbits++;
            end
            if (bus.done) ndone++;
        end
        bus.load = 1'b0;
        checks++;
        if (stream !== 8'hE8 || nbits != W || ndone != 1) begin
            errors++;
            $display("FAIL busy_word got %h bits=%0d done=%0d exp e8 bits=%0d done=1",
                     stream, nbits, ndone, W);
        end
    endtask

    task automatic test_reset_mid_word();
        int nbits = 0, ndone = 0;
        for (int i = 0; i < 16; i++) begin
            bus.load = (i == 0);
            bus.din  = W'($urandom);
            reset    = (i == 4);
            tick();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL midreset_cycle tick %0d got %b exp %b", tick_no, got_v, exp_v);
            end
            if (i == 4) begin
                checks++;
                if (bus.ready !== 1'b1 || bus.bit_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL midreset_after got ready=%b bit_valid=%b exp ready=1 bit_valid=0",
                             bus.ready, bus.bit_valid);
                end
            end
            if (bus.bit_valid) nbits++;
            if (bus.done) ndone++;
        end
        reset = 1'b0;
        checks++;
        if (ndone != 0 || nbits != 3) begin
            errors++;
            $display("FAIL midreset_abandon got done=%0d bits=%0d exp done=0 bits=3", ndone, nbits);
        end
        test_single_word(8'h0F, 8'hF1, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream = '0;
        int nbits = 0, ndone = 0, nclr = 0;
        int clr_at[2] = '{0, 0};
        for (int i = 0; i < 24; i++) begin
            bus.load = (i <= 11);
            bus.din  = (i == 0) ? 8'hA5 : 8'h3C;
            tick();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL b2b_cycle tick %0d got %b exp %b", tick_no, got_v, exp_v);
            end
            if (bus.conv_reset) begin
                if (nclr < 2) clr_at[nclr] = i;
                nclr++;
            end
            if (bus.bit_valid) begin
                if (nbits < 16) stream = {bus.out, stream[15:1]};
                nbits++;
            end
            if (bus.done) ndone++;
        end
        bus.load = 1'b0;
        checks++;
        if (nclr != 2 || clr_at[1] - clr_at[0] != W + 3) begin
            errors++;
            $display("FAIL b2b_spacing got clr=%0d gap=%0d exp clr=2 gap=%0d",
                     nclr, clr_at[1] - clr_at[0], W + 3);
        end
        checks++;
        if (stream !== 16'h3CA5 || nbits != 16 || ndone != 2) begin
            errors++;
            $display("FAIL b2b_streams got %h bits=%0d done=%0d exp 3ca5 bits=16 done=2",
                     stream, nbits, ndone);
        end
    endtask

    task automatic test_random_traffic();
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 39) == 0);
            bus.load = ($urandom_range(0, 2) == 0);
            bus.din  = W'($urandom);
            tick();
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random_cycle tick %0d got %b exp %b", tick_no, got_v, exp_v);
            end
        end
        reset    = 1'b0;
        bus.load = 1'b0;
        for (int i = 0; i < W + 4; i++) tick();
    endtask

    task automatic test_random_words();
        logic [W-1:0] w;
        for (int n = 0; n < 6; n++) begin
            w = W'($urandom);
            test_single_word(w, (~w) + 8'h01, "random_word");
        end
    endtask

    initial begin
        reset    = 1'b1;
        bus.load = 1'b0;
        bus.din  = '0;
        test_reset();
        test_single_word(8'hE8, 8'h18, "word_e8");
        test_single_word(8'h01, 8'hFF, "word_01");
        test_single_word(8'h80, 8'h80, "word_80");
        test_load_while_busy();
        test_reset_mid_word();
        test_back_to_back();
        test_random_words();
        test_random_traffic();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_word_feeder.md
Name: serial_word_feeder

Overview:
- Upstream stage of the serial two's complement converter FSM.
- Accepts a parallel WIDTH-bit word through a ready/load handshake.
- Pulses a one-cycle frame-clear to the converter, then shifts the word out LSB-first, one bit per clock.
- Signals completion so the next word can be loaded. Serial output bit and frame-clear connect directly to the converter's in and reset.

Parameters:
WIDTH, 8, bits per word shifted out (legal range 2..32)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
load  input  1  request to accept din; honoured only when ready=1
din  input  WIDTH  parallel word, sampled on the clk edge where load=1 and ready=1
ready  output  1  high when idle and able to accept a word
out  output  1  serial data bit to converter in, LSB first
bit_valid  output  1  high on each cycle where out carries a word bit
conv_reset  output  1  one-cycle frame-clear pulse to converter reset
done  output  1  one-cycle pulse after the last bit has been presented

Behaviour:
- One clock domain. reset is synchronous and active-high. All outputs are registered.
- Reset (sampled high on an edge), effective next cycle:
  - state=IDLE, shift register=0, bit counter=0.
  - ready=1, out=0, bit_valid=0, conv_reset=0, done=0.
- Reset overrides load and any in-progress word. A mid-word reset abandons the word with no done pulse and no further bits.
- State machine IDLE -> CLEAR -> SHIFT -> DONE -> IDLE.
- IDLE:
  - ready=1; all other outputs 0.
  - load=1 at edge k: capture din, counter=0, go to CLEAR.
  - load=0: stay in IDLE.
- CLEAR (cycle k+1):
  - conv_reset=1, ready=0, bit_valid=0, out=0.
  - Unconditionally go to SHIFT.
- SHIFT (cycles k+2 .. k+1+WIDTH):
  - In cycle k+2+i, out=din[i] and bit_valid=1, for i = 0..WIDTH-1.
  - Register shifts right one bit per cycle; counter increments.
  - When counter reaches WIDTH-1, go to DONE.
- DONE (cycle k+2+WIDTH):
  - done=1, out=0, bit_valid=0, ready=0.
  - Unconditionally go to IDLE; ready=1 in cycle k+3+WIDTH.
- Word throughput: one word per WIDTH+3 cycles.
- Handshake rules:
  - load while ready=0 is ignored. It is neither queued nor does it corrupt the word in flight.
  - din changes while ready=0 have no effect.
  - load held high continuously loads back-to-back words on each IDLE cycle.
- Counter width is ceil(log2(WIDTH)). No wrap beyond WIDTH-1 is ever reached.
- conv_reset and bit_valid are never high in the same cycle.
- done never coincides with bit_valid.

Test Plan:
1. Reset then idle: reset=1 for one edge, load=0 -> ready=1, out=0, conv_reset=0, done=0, bit_valid=0 on every cycle thereafter.
2. Single word, WIDTH=8, din=8'hE8, load at edge k:
   - conv_reset=1 only in k+1.
   - out = 0,0,0,1,0,1,1,1 with bit_valid=1 in k+2..k+9.
   - done=1 in k+10; ready=1 in k+11.
3. Integration with converter (out->in, conv_reset->reset), same word:
   - Converter output sequence LSB-first = 0,0,0,1,1,0,0,0, i.e. 8'h18, which is -8'hE8 mod 256.
   - Repeat with din=8'h01 -> 8'hFF, and din=8'h80 -> 8'h80.
4. Load while busy: load din=8'hE8, then pulse load with din=8'h55 during SHIFT:
   - Serial stream remains 8'hE8.
   - Only one done pulse.
   - 8'h55 is not emitted later.
5. Reset mid-word: assert reset during the third SHIFT cycle:
   - Next cycle ready=1 and bit_valid=0.
   - No done pulse.
   - A following load of 8'h0F shifts 1,1,1,1,0,0,0,0 correctly.
6. Back-to-back with load held high, din=8'hA5 then 8'h3C:
   - Words start exactly 11 cycles apart.
   - Each word is preceded by its own conv_reset pulse.
   - Bit streams are 1,0,1,0,0,1,0,1 and 0,0,1,1,1,1,0,0.
